// File: rtl/shake_rej_sampler.sv
// Rejection sampler: turns a SHAKE squeeze byte stream into N_COEFFS
// coefficients below Q, consuming 3 bytes per candidate with bit 23 masked.
// Optional macro SHAKE_REJ_STATS_EN adds a saturating reject_cnt output.
module shake_rej_sampler #(
  parameter int W        = 64,
  parameter int N_COEFFS = 256,
  parameter int Q        = 8380417
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  data_in,
  input  logic          valid_in,
  output logic          ready_out,
  output logic [22:0]   coeff_out,
  output logic [7:0]    coeff_idx,
  output logic          valid_out,
  input  logic          ready_in,
  output logic          done
`ifdef SHAKE_REJ_STATS_EN
  ,
  output logic [15:0]   reject_cnt
`endif
);

  localparam int WORD_BYTES = W / 8;
  // Worst case: 2 leftover bytes plus a freshly loaded word.
  localparam int BUF_BYTES  = WORD_BYTES + 2;
  localparam int BUF_W      = BUF_BYTES * 8;
  localparam int CNT_W      = $clog2(BUF_BYTES + 1);
  localparam int ACC_W      = $clog2(N_COEFFS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [ACC_W-1:0]   accept_cnt_q, accept_cnt_d;
  logic [22:0]        coeff_q, coeff_d;
  logic [7:0]         idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [15:0]        reject_q, reject_d;

  logic               in_sample;
  logic               cnt_open;
  logic               load;
  logic               extract;
  logic               out_hs;
  logic [22:0]        cand;

  assign in_sample = (state_q == SAMPLE);
  assign cnt_open  = (accept_cnt_q < ACC_W'(N_COEFFS));
  assign ready_out = in_sample && (byte_cnt_q <= CNT_W'(2)) && cnt_open;
  assign load      = ready_out && valid_in;
  // Disjoint from load because the byte_cnt ranges never overlap.
  assign extract   = in_sample && (byte_cnt_q >= CNT_W'(3)) && cnt_open &&
                     (!valid_q || ready_in);
  assign out_hs    = valid_q && ready_in;
  assign cand      = {buf_q[22:16], buf_q[15:0]};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    byte_cnt_d   = byte_cnt_q;
    accept_cnt_d = accept_cnt_q;
    coeff_d      = coeff_q;
    idx_d        = idx_q;
    valid_d      = valid_q;
    reject_d     = reject_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SAMPLE;
          buf_d        = '0;
          byte_cnt_d   = '0;
          accept_cnt_d = '0;
          idx_d        = '0;
          valid_d      = 1'b0;
          reject_d     = '0;
        end
      end

      SAMPLE: begin
        if (out_hs) valid_d = 1'b0;

        if (load) begin
          // Bytes above byte_cnt are always zero, so OR-ing places the word.
          buf_d      = buf_q | (BUF_W'(data_in) << {byte_cnt_q, 3'b000});
          byte_cnt_d = byte_cnt_q + CNT_W'(WORD_BYTES);
        end else if (extract) begin
          buf_d      = buf_q >> 24;
          byte_cnt_d = byte_cnt_q - CNT_W'(3);
          if (cand < 23'(Q)) begin
            coeff_d      = cand;
            idx_d        = accept_cnt_q[7:0];
            valid_d      = 1'b1;
            accept_cnt_d = accept_cnt_q + ACC_W'(1);
          end else if (reject_q != 16'hFFFF) begin
            reject_d = reject_q + 16'd1;
          end
        end

        if (out_hs && (accept_cnt_q == ACC_W'(N_COEFFS))) begin
          state_d    = DONE;
          buf_d      = '0;
          byte_cnt_d = '0;
        end
      end

      DONE: begin
        state_d    = IDLE;
        valid_d    = 1'b0;
        byte_cnt_d = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      accept_cnt_q <= '0;
      coeff_q      <= '0;
      idx_q        <= '0;
      valid_q      <= 1'b0;
      reject_q     <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      coeff_q      <= coeff_d;
      idx_q        <= idx_d;
      valid_q      <= valid_d;
      reject_q     <= reject_d;
    end
  end

  // NOTE: the byte buffer has no reset; it is zeroed on every start and its
  // contents are never observed before that.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign coeff_out = coeff_q;
  assign coeff_idx = idx_q;
  assign valid_out = valid_q;
  assign done      = (state_q == DONE);

`ifdef SHAKE_REJ_STATS_EN
  assign reject_cnt = reject_q;
`else
  logic unused_reject;
  assign unused_reject = ^reject_q;
`endif

endmodule

// File: tb/tb_shake_rej_sampler.sv
// Directed and model-checked bench for shake_rej_sampler; reject_cnt is
// checked only when SHAKE_REJ_STATS_EN is defined.
`timescale 1ns/1ps
module tb_shake_rej_sampler;

  localparam int Q = 8380417;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [22:0] coeff_out;
  logic [7:0]  coeff_idx;
  logic        valid_out;
  logic        ready_in;
  logic        done;
`ifdef SHAKE_REJ_STATS_EN
  logic [15:0] reject_cnt;
`endif

  shake_rej_sampler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .coeff_out (coeff_out),
    .coeff_idx (coeff_idx),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .done      (done)
`ifdef SHAKE_REJ_STATS_EN
    ,
    .reject_cnt(reject_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_rdy = 1'b0;

  // {idx, coeff} of every output handshake, and count of done pulses.
  logic [30:0] got_q[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) got_q.push_back({coeff_idx, coeff_out});
    if (!rst && done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) ready_in = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; valid_in = 1'b0; data_in = '0; ready_in = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Returns just after the edge on which the word was accepted.
  task automatic send_word(input logic [63:0] w, input string tag);
    bit ok = 1'b0;
    valid_in = 1'b1;
    data_in  = w;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = ready_out;
      step();
    end
    valid_in = 1'b0;
    check({tag, " word accepted"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_outputs(input int base, input int n, input string tag);
    for (int i = 0; i < 3000 && (got_q.size() - base) < n; i++) step();
    step(); step();
    check({tag, " output count"}, 64'(got_q.size() - base), 64'(n));
  endtask

  task automatic check_out(input string tag, input int k, input int idx, input int coeff);
    logic [30:0] exp_v;
    logic [30:0] got_v;
    exp_v = {8'(idx), 23'(coeff)};
    got_v = (k < got_q.size()) ? got_q[k] : 31'h7FFF_FFFF;
    check(tag, 64'(got_v), 64'(exp_v));
  endtask

  logic [7:0]  mbytes[$];
  logic [30:0] exp_q[$];

  initial begin
    int          base;
    int          done_base;
    int          nexp;
    int          guard;
    logic [63:0] w;
    logic [7:0]  b0, b1, b2;
    logic [22:0] t;

    // Reset wins over start, valid_in and ready_in in the same cycle.
    rst = 1'b1; start = 1'b1; valid_in = 1'b1; data_in = '1; ready_in = 1'b1;
    step(); step();
    check("rst ready_out", 64'(ready_out), 64'd0);
    check("rst valid_out", 64'(valid_out), 64'd0);
    check("rst done",      64'(done),      64'd0);
    check("rst coeff_out", 64'(coeff_out), 64'd0);
    check("rst coeff_idx", 64'(coeff_idx), 64'd0);
    rst = 1'b0; start = 1'b0;
    step();
    check("idle ignores valid_in", 64'(ready_out), 64'd0);
    valid_in = 1'b0;

    // Single word 0x01: coeffs 1 and 0, two bytes left over.
    do_start();
    base = got_q.size();
    send_word(64'h1, "t1");
    check("t1 no valid at accept edge", 64'(valid_out), 64'd0);
    step();
    check("t1 first coeff", 64'({valid_out, coeff_idx, coeff_out}), 64'({1'b1, 8'd0, 23'd1}));
    step();
    check("t1 second coeff", 64'({valid_out, coeff_idx, coeff_out}), 64'({1'b1, 8'd1, 23'd0}));
    step();
    check("t1 valid cleared", 64'(valid_out), 64'd0);
    check("t1 ready with 2 bytes", 64'(ready_out), 64'd1);
    check("t1 output count", 64'(got_q.size() - base), 64'd2);
    check_out("t1 out0", base, 0, 1);
    check_out("t1 out1", base + 1, 1, 0);

    // Triples FF FF 7F and 01 E0 7F rejected; 00 E0 7F, 05 00 80, 03 00 00 kept.
    do_reset();
    do_start();
    base = got_q.size();
    send_word(64'hE0007FE0017FFFFF, "t2a");
    step();
    check("t2 reject 1 no valid", 64'(valid_out), 64'd0);
    step();
    check("t2 reject 2 no valid", 64'(valid_out), 64'd0);
`ifdef SHAKE_REJ_STATS_EN
    check("t2 reject_cnt", 64'(reject_cnt), 64'd2);
`endif
    send_word(64'h000000038000057F, "t2b");
    wait_outputs(base, 3, "t2");
    check_out("t2 q-1 accepted", base, 0, 8380416);
    check_out("t2 bit23 masked", base + 1, 1, 5);
    check_out("t2 third", base + 2, 2, 3);
`ifdef SHAKE_REJ_STATS_EN
    check("t2 reject_cnt held", 64'(reject_cnt), 64'd2);
`endif

    // Back-pressure: coeff 1 held for 10 cycles; start is ignored mid-request.
    do_reset();
    do_start();
    ready_in = 1'b0;
    base = got_q.size();
    send_word(64'h1, "t3a");
    step();
    for (int i = 0; i < 10; i++) begin
      check("t3 hold", 64'({valid_out, ready_out, coeff_idx, coeff_out}),
            64'({1'b1, 1'b0, 8'd0, 23'd1}));
      start = (i == 3);
      step();
      start = 1'b0;
    end
    ready_in = 1'b1;
    wait_outputs(base, 2, "t3a");
    send_word(64'h207, "t3b");
    wait_outputs(base, 5, "t3b");
    check_out("t3 out0", base, 0, 1);
    check_out("t3 out1", base + 1, 1, 0);
    check_out("t3 leftover join", base + 2, 2, 458752);
    check_out("t3 out3", base + 3, 3, 2);
    check_out("t3 out4", base + 4, 4, 0);

    // Full request, random words and random ready_in, against a byte model.
    do_reset();
    do_start();
    rand_rdy = 1'b1;
    base = got_q.size();
    done_base = done_cnt;
    nexp = 0;
    guard = 0;
    mbytes.delete();
    exp_q.delete();
    while (nexp < 256 && guard < 400) begin
      w = (guard % 10 == 4) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      send_word(w, "t4");
      for (int b = 0; b < 8; b++) mbytes.push_back(w[8*b +: 8]);
      while (mbytes.size() >= 3 && nexp < 256) begin
        b0 = mbytes.pop_front();
        b1 = mbytes.pop_front();
        b2 = mbytes.pop_front();
        t  = {b2[6:0], b1, b0};
        if (t < 23'(Q)) begin
          exp_q.push_back({nexp[7:0], t});
          nexp++;
        end
      end
      guard++;
    end
    check("t4 ready_out low after last word", 64'(ready_out), 64'd0);
    for (int i = 0; i < 3000 && done_cnt == done_base; i++) step();
    step(); step();
    rand_rdy = 1'b0;
    ready_in = 1'b1;
    check("t4 done pulses", 64'(done_cnt - done_base), 64'd1);
    check("t4 ready_out after done", 64'(ready_out), 64'd0);
    check("t4 valid_out after done", 64'(valid_out), 64'd0);
    check("t4 output count", 64'(got_q.size() - base), 64'd256);
    for (int i = 0; i < 256; i++)
      check($sformatf("t4 out%0d", i), 64'(got_q[base + i]), 64'(exp_q[i]));

    // Reset in the middle of a request, then a clean restart.
    do_reset();
    do_start();
    base = got_q.size();
    for (int k = 0; k < 100 && (got_q.size() - base) < 100; k++) send_word(64'h0, "t5a");
    rst = 1'b1;
    step();
    check("t5 rst valid_out", 64'(valid_out), 64'd0);
    check("t5 rst coeff_idx", 64'(coeff_idx), 64'd0);
    check("t5 rst ready_out", 64'(ready_out), 64'd0);
    rst = 1'b0;
    step();
    do_start();
    base = got_q.size();
    send_word(64'h1, "t5b");
    wait_outputs(base, 2, "t5b");
    step(); step();
    check("t5 no stale outputs", 64'(got_q.size() - base), 64'd2);
    check_out("t5 out0", base, 0, 1);
    check_out("t5 out1", base + 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shake_rej_sampler.md
SHAKE_REJ_SAMPLER -- requirements
Module: shake_rej_sampler

Interface
REQ-001 Parameter W, 64, input word width in bits; the byte count per word is W/8 = 8.
REQ-002 Parameter N_COEFFS, 256, number of accepted coefficients per request.
REQ-003 Parameter Q, 8380417, rejection bound.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request strobe; honoured only in IDLE.
REQ-007 data_in  in  W  SHAKE squeeze word from the sponge output; byte 0 is data_in[7:0].
REQ-008 valid_in  in  1  data_in is valid.
REQ-009 ready_out  out  1  the block accepts data_in this cycle.
REQ-010 coeff_out  out  23  sampled coefficient.
REQ-011 coeff_idx  out  8  index of coeff_out within the polynomial.
REQ-012 valid_out  out  1  coeff_out and coeff_idx are valid.
REQ-013 ready_in  in  1  the downstream consumer accepts coeff_out.
REQ-014 done  out  1  one-cycle pulse when the request is complete.

Function
REQ-015 The FSM SHALL have three states, IDLE, SAMPLE and DONE; transitions are IDLE->SAMPLE on start, SAMPLE->DONE on the N_COEFFS-th output handshake, and DONE->IDLE unconditionally after one cycle.
REQ-016 On entry to SAMPLE, the byte buffer (10 bytes), byte_cnt, accept_cnt and coeff_idx SHALL be zero.
REQ-017 A word is accepted when valid_in and ready_out are both high; ready_out SHALL be 1 only in SAMPLE with byte_cnt <= 2 and accept_cnt < N_COEFFS.
REQ-018 An accepted word SHALL be appended at byte position byte_cnt, and byte_cnt SHALL increase by 8.
REQ-019 Extraction SHALL occur in SAMPLE when byte_cnt >= 3, accept_cnt < N_COEFFS, and the output slot is free (!valid_out || ready_in).
REQ-020 Loading and extraction are mutually exclusive within a cycle by construction.
REQ-021 Extraction SHALL form t = {byte2[6:0], byte1, byte0} (byte2 bit 7 masked), shift the buffer down by 3 bytes, and decrease byte_cnt by 3.
REQ-022 If t < Q, the extracted value SHALL be registered: coeff_out = t, coeff_idx = accept_cnt, valid_out = 1, and accept_cnt increments.
REQ-023 If t >= Q, no output SHALL be produced; valid_out clears if the previous coefficient handshook that cycle, and the 3 bytes are still consumed.
REQ-024 When valid_out = 1 and ready_in = 0, coeff_out and coeff_idx SHALL hold stable.
REQ-025 valid_out SHALL clear on a handshake when no new coefficient is registered in the same cycle.
REQ-026 Latency: for a word accepted at edge k with byte_cnt = 0 and a free slot, valid_out SHALL be 1 after edge k+1.
REQ-027 When accept_cnt = N_COEFFS, loading and extraction SHALL stop; the FSM moves to DONE once the last coefficient (idx 255) handshakes.
REQ-028 In DONE, done = 1, ready_out = 0, valid_out = 0, and leftover buffer bytes SHALL be discarded (byte_cnt cleared).
REQ-029 start SHALL be ignored in SAMPLE and DONE.
REQ-030 valid_in in IDLE or DONE SHALL be ignored (ready_out = 0).

Reset
REQ-031 When rst = 1 at a rising edge, the state SHALL be IDLE and ready_out, valid_out, done, coeff_out, coeff_idx, byte_cnt and accept_cnt SHALL all be 0, including in the middle of a request.
REQ-032 rst SHALL take priority over start, valid_in and ready_in in the same cycle.

Configuration
REQ-033 With SHAKE_REJ_STATS_EN defined, the block SHALL add output reject_cnt (16 bits), cleared on start and rst, incremented per rejected triple, saturating at 0xFFFF, and held after DONE.
REQ-034 Without SHAKE_REJ_STATS_EN, the reject_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Reset, start, data_in = 0x0000000000000001, ready_in = 1 -> coeffs 1 (idx 0) and 0 (idx 1); byte_cnt = 2 remaining; first valid_out one edge after the accept.
REQ-036 Triples FF FF 7F and 01 E0 7F (t = Q) -> both rejected, no valid_out, reject_cnt = 2 (macro on); triple 00 E0 7F -> coeff 8380416 accepted.
REQ-037 Triple 05 00 80 -> coeff_out = 5 (bit 23 masked).
REQ-038 ready_in held 0 for 10 cycles while coeff 1 is pending -> coeff_out/coeff_idx stable, ready_out = 0 once byte_cnt >= 3, no bytes lost after release.
REQ-039 Random words, random ready_in -> exactly 256 outputs with idx 0..255 in order, one done pulse, ready_out = 0 after the last accept, results match the software model.
REQ-040 rst asserted after 100 coefficients, then a new start -> idx restarts at 0, no stale valid_out or leftover bytes.
